// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore FSM with combinational opcode/funct decode.
// Define ILLEGAL_TRAP_EN to latch illegal instructions into a sticky ERROR state.
module multicycle_controller #(
   parameter int unsigned MEM_LAT = 0,
   parameter int unsigned CNT_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       RegWrite,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_ERROR    = 4'd15
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [2:0] IMM_I      = 3'b000;
   localparam logic [2:0] IMM_S      = 3'b001;
   localparam logic [2:0] IMM_B      = 3'b010;
   localparam logic [2:0] IMM_J      = 3'b011;
   localparam logic [2:0] IMM_U      = 3'b100;

   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

`ifdef ILLEGAL_TRAP_EN
   localparam state_e ILL_NEXT = S_ERROR;
`else
   localparam state_e ILL_NEXT = S_FETCH;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             lat_done, mem_state, ill_det;
   logic             br_taken, br_bad;
   logic [3:0]       alu_op;

   assign lat_done  = (cnt_q == LAT);
   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

   // Branch condition table; funct3 010/011 are not RV32I branches.
   always_comb begin
      br_taken = 1'b0;
      br_bad   = 1'b0;
      case (funct3)
         3'b000:  br_taken = zero;
         3'b001:  br_taken = ~zero;
         3'b100:  br_taken = lt;
         3'b101:  br_taken = ~lt;
         3'b110:  br_taken = ltu;
         3'b111:  br_taken = ~ltu;
         default: br_bad   = 1'b1;
      endcase
   end

   // funct7b5 means sub only for register ops; for immediates it is an imm bit.
   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000:  alu_op = (funct7b5 && state_q == S_EXECR) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ill_det = 1'b0;
      case (state_q)
         S_FETCH:    if (lat_done) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default: begin
                  ill_det = 1'b1;
                  state_d = ILL_NEXT;
               end
            endcase
         end
         S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (lat_done) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (lat_done) state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC:
                     state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH: begin
            if (br_bad) begin
               ill_det = 1'b1;
               state_d = ILL_NEXT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_ERROR:    state_d = ILL_NEXT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Counter restarts on every transition so each memory visit gets a fresh wait.
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && mem_state) cnt_d = cnt_q + CNT_W'(1);
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q | ill_det;
`else
      illegal_d = ill_det;
`endif
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ImmSrc     = IMM_I;
      ALUControl = ALU_ADD;
      RegWrite   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB = SRCB_FOUR;
            IRWrite = lat_done;
            PCWrite = lat_done;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = opcode[5] ? IMM_S : IMM_I;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = alu_op;
         end
         S_EXECI: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = alu_op;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = ALU_SUB;
            PCWrite    = br_taken & ~br_bad;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            ImmSrc  = IMM_J;
            PCWrite = 1'b1;
         end
         S_JALR: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURES;
            PCWrite   = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_U;
         end
         S_AUIPC: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_U;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances at MEM_LAT 0/1/2 share stimulus;
// expected outputs are queued when a test is driven and popped when sampled.
module tb_multicycle_controller;

   typedef struct packed {
      logic       PCWrite;
      logic       AdrSrc;
      logic       MemWrite;
      logic       IRWrite;
      logic [1:0] ResultSrc;
      logic [1:0] ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [2:0] ImmSrc;
      logic [3:0] ALUControl;
      logic       RegWrite;
      logic       illegal;
      logic [3:0] state;
   } out_t;

   typedef struct {
      string      name;
      int         lat;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z, lt, ltu;
      int         cyc;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
   out_t       obs [3];

   int   errors = 0;
   int   checks = 0;
   out_t exp_q [$];
   string name_q [$];
   vec_t tbl [$];
   out_t FULL, TR;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic       pcw, adr, mw, irw, rw, ill;
      logic [1:0] rs, sa, sb;
      logic [2:0] imm;
      logic [3:0] aluc, st;
      multicycle_controller #(.MEM_LAT(g), .CNT_W(4)) u_dut (
         .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
         .zero(zero), .lt(lt), .ltu(ltu),
         .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw), .ResultSrc(rs),
         .ALUSrcA(sa), .ALUSrcB(sb), .ImmSrc(imm), .ALUControl(aluc), .RegWrite(rw),
         .illegal(ill), .state(st)
      );
      assign obs[g] = {pcw, adr, mw, irw, rs, sa, sb, imm, aluc, rw, ill, st};
   end

   function automatic out_t o(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                              input logic [2:0] imm, input logic [3:0] alu,
                              input logic rw, ill, input logic [3:0] s);
      return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill, s};
   endfunction

   function automatic out_t st(input logic [3:0] s, input logic pcw, irw, mw, rw, ill);
      out_t r = '0;
      r.state = s; r.PCWrite = pcw; r.IRWrite = irw; r.MemWrite = mw;
      r.RegWrite = rw; r.illegal = ill;
      return r;
   endfunction

   task automatic add(input string n, input int lat, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, z, l, lu, input int cyc, input out_t e);
      vec_t v;
      v.name = n; v.lat = lat; v.op = op; v.f3 = f3; v.f7 = f7;
      v.z = z; v.lt = l; v.ltu = lu; v.cyc = cyc; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic push(input string n, input out_t e);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic check(input int lat, input out_t mask);
      out_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ((obs[lat] & mask) !== (e & mask)) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, obs[lat] & mask, e & mask);
      end
   endtask

   // Leaves the bench at a falling edge with cycle 0 (FETCH) current.
   task automatic do_reset(input logic [6:0] op, input logic [2:0] f3, input logic f7, z, l, lu);
      @(negedge clk);
      rst_n = 1'b0;
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int lat, input int n, input out_t mask);
      for (int c = 0; c < n; c++) begin
         if (c != 0) @(negedge clk);
         #1 check(lat, mask);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      FULL = '1;
      TR   = st(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      add("reset_fetch_l0", 0, 7'b0110011, 3'b000, 0, 0, 0, 0, 0, o(1,0,0,1,2'b00,2'b00,2'b10,3'b000,4'b0000,0,0,4'd0));
      add("reset_fetch_l2", 2, 7'b0110011, 3'b000, 0, 0, 0, 0, 0, o(0,0,0,0,2'b00,2'b00,2'b10,3'b000,4'b0000,0,0,4'd0));
      add("fetch_l1_c1",    1, 7'b0110011, 3'b000, 0, 0, 0, 0, 1, o(1,0,0,1,2'b00,2'b00,2'b10,3'b000,4'b0000,0,0,4'd0));
      add("decode",         0, 7'b0110011, 3'b000, 0, 0, 0, 0, 1, o(0,0,0,0,2'b00,2'b01,2'b01,3'b010,4'b0000,0,0,4'd1));
      add("execr_add",      0, 7'b0110011, 3'b000, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0000,0,0,4'd6));
      add("execr_sub",      0, 7'b0110011, 3'b000, 1, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd6));
      add("execr_sra",      0, 7'b0110011, 3'b101, 1, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b1001,0,0,4'd6));
      add("execr_srl",      0, 7'b0110011, 3'b101, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b1000,0,0,4'd6));
      add("execr_sltu",     0, 7'b0110011, 3'b011, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0110,0,0,4'd6));
      add("execr_and",      0, 7'b0110011, 3'b111, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0010,0,0,4'd6));
      add("execi_addi_f7",  0, 7'b0010011, 3'b000, 1, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0,0,4'd7));
      add("execi_srai",     0, 7'b0010011, 3'b101, 1, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b1001,0,0,4'd7));
      add("execi_xori",     0, 7'b0010011, 3'b100, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0100,0,0,4'd7));
      add("execi_slli",     0, 7'b0010011, 3'b001, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0111,0,0,4'd7));
      add("aluwb",          0, 7'b0110011, 3'b000, 0, 0, 0, 0, 3, o(0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,1,0,4'd8));
      add("memadr_load",    0, 7'b0000011, 3'b010, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0,0,4'd2));
      add("memadr_store",   0, 7'b0100011, 3'b010, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'b0000,0,0,4'd2));
      add("memread_l0",     0, 7'b0000011, 3'b010, 0, 0, 0, 0, 3, o(0,1,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,0,4'd3));
      add("memwb_l0",       0, 7'b0000011, 3'b010, 0, 0, 0, 0, 4, o(0,0,0,0,2'b01,2'b00,2'b00,3'b000,4'b0000,1,0,4'd4));
      add("memread_l2_mid", 2, 7'b0000011, 3'b010, 0, 0, 0, 0, 6, o(0,1,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,0,4'd3));
      add("memwb_l2",       2, 7'b0000011, 3'b010, 0, 0, 0, 0, 8, o(0,0,0,0,2'b01,2'b00,2'b00,3'b000,4'b0000,1,0,4'd4));
      add("memwrite_l0",    0, 7'b0100011, 3'b010, 0, 0, 0, 0, 3, o(0,1,1,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,0,4'd5));
      add("jal",            0, 7'b1101111, 3'b000, 0, 0, 0, 0, 2, o(1,0,0,0,2'b00,2'b01,2'b10,3'b011,4'b0000,0,0,4'd10));
      add("jal_link",       0, 7'b1101111, 3'b000, 0, 0, 0, 0, 3, o(0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,1,0,4'd8));
      add("jalr",           0, 7'b1100111, 3'b000, 0, 0, 0, 0, 2, o(1,0,0,0,2'b10,2'b10,2'b01,3'b000,4'b0000,0,0,4'd11));
      add("lui",            0, 7'b0110111, 3'b000, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b11,2'b01,3'b100,4'b0000,0,0,4'd12));
      add("auipc",          0, 7'b0010111, 3'b000, 0, 0, 0, 0, 2, o(0,0,0,0,2'b00,2'b01,2'b01,3'b100,4'b0000,0,0,4'd13));
      add("beq_z1",  0, 7'b1100011, 3'b000, 0, 1, 0, 0, 2, o(1,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("beq_z0",  0, 7'b1100011, 3'b000, 0, 0, 1, 1, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bne_z0",  0, 7'b1100011, 3'b001, 0, 0, 0, 0, 2, o(1,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bne_z1",  0, 7'b1100011, 3'b001, 0, 1, 0, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("blt_lt1", 0, 7'b1100011, 3'b100, 0, 0, 1, 0, 2, o(1,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("blt_ltu", 0, 7'b1100011, 3'b100, 0, 1, 0, 1, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bge_lt1", 0, 7'b1100011, 3'b101, 0, 0, 1, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bge_lt0", 0, 7'b1100011, 3'b101, 0, 0, 0, 1, 2, o(1,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bltu_1",  0, 7'b1100011, 3'b110, 0, 0, 0, 1, 2, o(1,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bltu_0",  0, 7'b1100011, 3'b110, 0, 1, 1, 0, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bgeu_0",  0, 7'b1100011, 3'b111, 0, 0, 1, 0, 2, o(1,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("bgeu_1",  0, 7'b1100011, 3'b111, 0, 0, 0, 1, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
      add("br_done", 0, 7'b1100011, 3'b000, 0, 1, 0, 0, 3, o(1,0,0,1,2'b00,2'b00,2'b10,3'b000,4'b0000,0,0,4'd0));
      add("br_f3_010", 0, 7'b1100011, 3'b010, 0, 1, 1, 1, 2, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0,4'd9));
`ifdef ILLEGAL_TRAP_EN
      add("br_f3_011_trap", 0, 7'b1100011, 3'b011, 0, 1, 1, 1, 3, o(0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,1,4'd15));
`else
      add("br_f3_011_nop",  0, 7'b1100011, 3'b011, 0, 1, 1, 1, 3, o(1,0,0,1,2'b00,2'b00,2'b10,3'b000,4'b0000,0,1,4'd0));
`endif

      foreach (tbl[i]) begin
         do_reset(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].lt, tbl[i].ltu);
         push(tbl[i].name, tbl[i].exp);
         repeat (tbl[i].cyc) @(negedge clk);
         #1 check(tbl[i].lat, FULL);
      end

      // R-type add, no memory latency
      do_reset(7'b0110011, 3'b000, 0, 0, 0, 0);
      push("radd_c0", st(4'd0, 1, 1, 0, 0, 0));
      push("radd_c1", st(4'd1, 0, 0, 0, 0, 0));
      push("radd_c2", st(4'd6, 0, 0, 0, 0, 0));
      push("radd_c3", st(4'd8, 0, 0, 0, 1, 0));
      push("radd_c4", st(4'd0, 1, 1, 0, 0, 0));
      drain(0, 5, TR);

      // lw with two wait cycles on each memory visit
      do_reset(7'b0000011, 3'b010, 0, 0, 0, 0);
      push("lw_c0", st(4'd0, 0, 0, 0, 0, 0));
      push("lw_c1", st(4'd0, 0, 0, 0, 0, 0));
      push("lw_c2", st(4'd0, 1, 1, 0, 0, 0));
      push("lw_c3", st(4'd1, 0, 0, 0, 0, 0));
      push("lw_c4", st(4'd2, 0, 0, 0, 0, 0));
      push("lw_c5", st(4'd3, 0, 0, 0, 0, 0));
      push("lw_c6", st(4'd3, 0, 0, 0, 0, 0));
      push("lw_c7", st(4'd3, 0, 0, 0, 0, 0));
      push("lw_c8", st(4'd4, 0, 0, 0, 1, 0));
      push("lw_c9", st(4'd0, 0, 0, 0, 0, 0));
      drain(2, 10, TR);

      // sw with one wait cycle
      do_reset(7'b0100011, 3'b010, 0, 0, 0, 0);
      push("sw_c0", st(4'd0, 0, 0, 0, 0, 0));
      push("sw_c1", st(4'd0, 1, 1, 0, 0, 0));
      push("sw_c2", st(4'd1, 0, 0, 0, 0, 0));
      push("sw_c3", st(4'd2, 0, 0, 0, 0, 0));
      push("sw_c4", st(4'd5, 0, 0, 1, 0, 0));
      push("sw_c5", st(4'd5, 0, 0, 1, 0, 0));
      push("sw_c6", st(4'd0, 0, 0, 0, 0, 0));
      drain(1, 7, TR);

      // Reset asserted mid-MEMWRITE, then a clean fetch
      do_reset(7'b0100011, 3'b010, 0, 0, 0, 0);
      push("swr_c0", st(4'd0, 0, 0, 0, 0, 0));
      push("swr_c1", st(4'd0, 1, 1, 0, 0, 0));
      push("swr_c2", st(4'd1, 0, 0, 0, 0, 0));
      push("swr_c3", st(4'd2, 0, 0, 0, 0, 0));
      push("swr_c4", st(4'd5, 0, 0, 1, 0, 0));
      push("rst_mid_memwrite", o(0,0,0,0,2'b00,2'b00,2'b10,3'b000,4'b0000,0,0,4'd0));
      push("post_rst_c0", st(4'd0, 0, 0, 0, 0, 0));
      push("post_rst_c1", st(4'd0, 1, 1, 0, 0, 0));
      push("post_rst_c2", st(4'd1, 0, 0, 0, 0, 0));
      drain(1, 5, TR);
      #2 rst_n = 1'b0;
      #1 check(1, FULL);
      @(negedge clk);
      rst_n = 1'b1;
      drain(1, 3, TR);

      // Illegal opcode 0000000
      do_reset(7'b0000000, 3'b000, 0, 0, 0, 0);
      push("ill_c0", st(4'd0, 1, 1, 0, 0, 0));
      push("ill_c1", st(4'd1, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_TRAP_EN
      push("ill_trap_c2", st(4'd15, 0, 0, 0, 0, 1));
      drain(0, 3, TR);
      push("ill_trap_hold", o(0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,1,4'd15));
      repeat (20) @(negedge clk);
      #1 check(0, FULL);
`else
      push("ill_nop_c2", st(4'd0, 1, 1, 0, 0, 1));
      push("ill_nop_c3", st(4'd1, 0, 0, 0, 0, 0));
      drain(0, 4, TR);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
